mouse_receiver: RTL
===================

MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200000: CLK cycles without a PS/2 falling edge before a frame in progress is aborted.
REQ-002 The block SHALL have port CLK, input, 1 bit: system clock, 100 MHz.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset, synchronous and active-low, sampled on the CLK rising edge.
REQ-004 The block SHALL have port CLK_MOUSE_IN, input, 1 bit: raw PS/2 clock line from the mouse.
REQ-005 The block SHALL have port DATA_MOUSE_IN, input, 1 bit: raw PS/2 data line from the mouse.
REQ-006 The block SHALL have port READ_ENABLE, input, 1 bit: receiving permitted; driven by the mouse master state machine.
REQ-007 The block SHALL have port BYTE_READ, output, 8 bits: last received data byte.
REQ-008 The block SHALL have port BYTE_ERROR_CODE, output, 2 bits: bit0 = parity error, bit1 = stop-bit error.
REQ-009 The block SHALL have port BYTE_READY, output, 1 bit: one-cycle strobe; BYTE_READ and BYTE_ERROR_CODE are valid in the same cycle.
REQ-010 The block SHALL have port RX_STATE, output, 4 bits: one-hot current state, for debug.

Function
REQ-011 CLK_MOUSE_IN and DATA_MOUSE_IN SHALL each pass through a 2-flop synchronizer.
REQ-012 A falling edge SHALL be detected as (previous synchronized clock = 1) and (current synchronized clock = 0).
REQ-013 All data bits SHALL be sampled from synchronized data in the edge-detect cycle.
REQ-014 States SHALL be one-hot: S_IDLE=0001, S_DATA=0010, S_PARITY=0100, S_STOP=1000.
REQ-015 S_IDLE SHALL move to S_DATA on a falling edge with data=0 and READ_ENABLE=1.
REQ-016 In S_IDLE, a falling edge with data=1 SHALL be ignored and the state SHALL stay S_IDLE.
REQ-017 S_DATA SHALL shift in 8 bits LSB first on successive edges, using a 3-bit bit counter.
REQ-018 S_DATA SHALL move to S_PARITY on the edge that captures bit 7.
REQ-019 S_PARITY SHALL capture the parity bit on the next edge and move to S_STOP.
REQ-020 Parity SHALL be odd: parity error = ~^{data[7:0], parity_bit}.
REQ-021 S_STOP SHALL, on the next edge: load BYTE_READ, set BYTE_ERROR_CODE = {stop_bit==0, parity_error}, pulse BYTE_READY high for exactly 1 cycle, and return to S_IDLE.
REQ-022 Latency: BYTE_READY SHALL rise on the cycle after the stop-bit edge is detected.
REQ-023 Errored frames SHALL still strobe BYTE_READY, with BYTE_READ holding the received data.
REQ-024 BYTE_READ and BYTE_ERROR_CODE SHALL hold their values until the next strobe.
REQ-025 If READ_ENABLE=0 in S_DATA, S_PARITY or S_STOP, the block SHALL abort to S_IDLE on the next cycle, with no strobe and outputs unchanged.
REQ-026 Abort (REQ-025) SHALL take priority when it coincides with an edge.
REQ-027 The bit counter SHALL reset to 0 on every entry to S_DATA; there SHALL be no wrap-around beyond 8 data bits.
REQ-028 A frame SHALL never complete with fewer than 11 edges.

Reset
REQ-029 When RESET=0 at a CLK edge, the state SHALL become S_IDLE.
REQ-030 RESET SHALL clear BYTE_READ to 8'h00, BYTE_ERROR_CODE to 2'b00, BYTE_READY to 0, RX_STATE to 4'b0001, the bit counter, the shift register and the timeout counter.
REQ-031 RESET SHALL set the synchronizer flops to 1 (idle bus level).
REQ-032 Reset mid-frame SHALL discard the partial frame with no strobe.

Configuration
REQ-033 The macro SHALL be MOUSE_RX_TIMEOUT_EN.
REQ-034 With MOUSE_RX_TIMEOUT_EN defined, a counter SHALL run in every non-idle state and clear on each falling edge.
REQ-035 With MOUSE_RX_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 the block SHALL return to S_IDLE with no strobe and clear the counter.
REQ-036 With MOUSE_RX_TIMEOUT_EN defined, a timeout coinciding with an edge SHALL give the edge priority.
REQ-037 With MOUSE_RX_TIMEOUT_EN undefined, no counter SHALL be synthesized and a partial frame SHALL wait indefinitely; only READ_ENABLE=0 or RESET recovers it.

Verification
REQ-038 Clean 0xFA frame (start 0, data LSB first, parity 1, stop 1) -> BYTE_READY strobes once, BYTE_READ=8'hFA, BYTE_ERROR_CODE=2'b00.
REQ-039 0xAA frame with parity 0 -> BYTE_READ=8'hAA, BYTE_ERROR_CODE=2'b01; 0xAA frame with parity 1 and stop 0 -> BYTE_ERROR_CODE=2'b10.
REQ-040 Back-to-back frames 0x08, 0x05, 0xFE -> three single-cycle strobes, values in that order, codes 00.
REQ-041 With MOUSE_RX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, stall the PS/2 clock after 4 data bits for 1200 cycles -> no strobe and RX_STATE=0001; then a 0xF4 frame (parity 0) -> BYTE_READ=8'hF4, code 00.
REQ-042 READ_ENABLE dropped after the parity bit -> no strobe and BYTE_READ unchanged; with READ_ENABLE=0 for a full 0xFF frame -> no strobe.
REQ-043 RESET=0 for 1 cycle after bit 5 -> RX_STATE=0001 and all outputs at reset values; a following 0xAA frame with parity 1 -> received correctly.

Source files
------------

// File: rtl/mouse_receiver.sv
// PS/2 mouse byte receiver: synchronises the raw PS/2 lines and deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Optional frame timeout enabled by defining MOUSE_RX_TIMEOUT_EN.
module mouse_receiver #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY,
    output logic [3:0] RX_STATE
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_DATA   = 4'b0010,
        S_PARITY = 4'b0100,
        S_STOP   = 4'b1000
    } state_t;

    state_t     r_state;
    logic       r_clk_s1;
    logic       r_clk_s2;
    logic       r_clk_prev;
    logic       r_dat_s1;
    logic       r_dat_s2;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_par;
    logic [7:0] r_byte;
    logic [1:0] r_err;
    logic       r_ready;

    logic       w_fall;
    logic       w_data;
    logic       w_abort;
    logic       w_tmo;

    assign w_fall  = r_clk_prev & ~r_clk_s2;
    assign w_data  = r_dat_s2;
    assign w_abort = (r_state != S_IDLE) & ~READ_ENABLE;

    // Two-flop synchronisers plus one delayed clock copy for edge detect
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= CLK_MOUSE_IN;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= DATA_MOUSE_IN;
            r_dat_s2   <= r_dat_s1;
        end
    end

`ifdef MOUSE_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo;

    // An edge in the same cycle wins over an expiring timeout
    assign w_tmo = (r_state != S_IDLE) & ~w_fall & (r_tmo == TMO_LAST);

    // Idle-time counter, runs only while a frame is in progress
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_tmo <= '0;
        end else if (r_state == S_IDLE || w_fall || w_tmo) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // Frame FSM with registered byte, error code and one-cycle strobe
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_par    <= 1'b0;
            r_byte   <= 8'h00;
            r_err    <= 2'b00;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_abort || w_tmo) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_fall && !w_data && READ_ENABLE) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (w_fall) begin
                            r_shift  <= {w_data, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= S_PARITY;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_fall) begin
                            r_par   <= w_data;
                            r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_fall) begin
                            r_byte  <= r_shift;
                            r_err   <= {~w_data, ~^{r_shift, r_par}};
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign BYTE_READ       = r_byte;
    assign BYTE_ERROR_CODE = r_err;
    assign BYTE_READY      = r_ready;
    assign RX_STATE        = r_state;

endmodule
